riscv_alu_stall_ctrl: RTL and testbench

- Sits in the EX stage and consumes the multicycle-latency handshake produced by the pipelined ALU: `stall_cycles`, `out_o`, and the destination register.
- Converts a nonzero cycle count into a precise EX-stage freeze (`stall_o`) for exactly that many cycles.
- Then captures the ALU result into the EX/MEM pipeline register.
- Also honours back-pressure from MEM and flushes from branch resolution, and keeps a running count of ALU-induced stall cycles.

---
 rtl/riscv_alu_stall_ctrl_pkg.sv | 17 +
 rtl/riscv_stall_counter.sv | 38 +++
 rtl/riscv_alu_stall_ctrl.sv | 175 +++++++++++++++++
 tb/tb_riscv_alu_stall_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_stall_ctrl_pkg.sv
// Shared definitions for the EX-stage multicycle ALU stall controller.
// The state encoding and count width are also used by the ALU wrapper.
package riscv_alu_stall_ctrl_pkg;

    localparam int STALL_W_DEFAULT = 5;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_WAIT    = 2'd1;
    localparam logic [1:0] STATE_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = STATE_IDLE,
        ST_WAIT    = STATE_WAIT,
        ST_RELEASE = STATE_RELEASE
    } alu_stall_state_e;

endpackage

// File: rtl/riscv_stall_counter.sv
// Loadable down-counter that saturates at zero and flags count == 1.
// Shared between the ALU stall controller and the load-use hazard unit.
module riscv_stall_counter
    import riscv_alu_stall_ctrl_pkg::*;
#(
    parameter int WIDTH = STALL_W_DEFAULT
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             count_is_one
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count        = count_r;
    assign count_is_one = (count_r == ONE);

endmodule

// File: rtl/riscv_alu_stall_ctrl.sv
// EX-stage controller turning the ALU's multicycle latency into a precise
// pipeline freeze, then capturing the result into the EX/MEM register.
module riscv_alu_stall_ctrl
    import riscv_alu_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = STALL_W_DEFAULT,
    parameter int DATA_W  = 32,
    parameter int PERF_W  = 32
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [STALL_W-1:0] stall_cycles_i,
    input  logic [DATA_W-1:0]  alu_result_i,
    input  logic [4:0]         rd_i,
    input  logic               flush_i,
    input  logic               mem_stall_i,
    output logic               stall_o,
    output logic               valid_o,
    output logic [DATA_W-1:0]  result_o,
    output logic [4:0]         rd_o,
    output logic               busy_o,
    output logic [PERF_W-1:0]  perf_stall_cnt_o
);

    localparam logic [STALL_W-1:0] N_ZERO = {STALL_W{1'b0}};
    localparam logic [STALL_W-1:0] N_ONE  = STALL_W'(1);

    alu_stall_state_e   state_r;
    alu_stall_state_e   state_next_s;
    logic [STALL_W-1:0] count_s;
    logic               count_is_one_s;
    logic               cnt_load_s;
    logic [STALL_W-1:0] cnt_load_value_s;
    logic               cnt_enable_s;
    logic               capture_s;
    logic               alu_stall_s;
    logic               perf_inc_s;
    logic               valid_r;
    logic [DATA_W-1:0]  result_r;
    logic [4:0]         rd_r;
    logic [PERF_W-1:0]  perf_cnt_r;

    riscv_stall_counter #(
        .WIDTH (STALL_W)
    ) u_stall_counter (
        .clk          (clock_i),
        .srst         (reset_i),
        .load         (cnt_load_s),
        .load_value   (cnt_load_value_s),
        .enable       (cnt_enable_s),
        .count        (count_s),
        .count_is_one (count_is_one_s)
    );

    // Next-state, counter control and capture decision.
    always_comb begin
        state_next_s     = state_r;
        cnt_load_s       = 1'b0;
        cnt_load_value_s = N_ZERO;
        cnt_enable_s     = 1'b0;
        capture_s        = 1'b0;
        if (flush_i) begin
            state_next_s = ST_IDLE;
            cnt_load_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (valid_i && !mem_stall_i) begin
                        if (stall_cycles_i == N_ZERO) begin
                            capture_s = 1'b1;
                        end else begin
                            cnt_load_s       = 1'b1;
                            cnt_load_value_s = stall_cycles_i - N_ONE;
                            state_next_s     = (stall_cycles_i == N_ONE) ? ST_RELEASE : ST_WAIT;
                        end
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // The ALU units are free-running, so MEM back-pressure never pauses this.
                    cnt_enable_s = 1'b1;
                    if (count_is_one_s || (count_s == N_ZERO)) begin
                        state_next_s = ST_RELEASE;
                    end else begin
                        state_next_s = ST_WAIT;
                    end
                end
                ST_RELEASE: begin
                    if (!mem_stall_i) begin
                        capture_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_RELEASE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // ALU-induced freeze request, the combined stall and the perf increment.
    always_comb begin
        alu_stall_s = 1'b0;
        case (state_r)
            ST_IDLE:    alu_stall_s = valid_i && (stall_cycles_i != N_ZERO);
            ST_WAIT:    alu_stall_s = 1'b1;
            ST_RELEASE: alu_stall_s = 1'b0;
            default:    alu_stall_s = 1'b0;
        endcase
        if (reset_i) begin
            stall_o    = mem_stall_i;
            perf_inc_s = 1'b0;
        end else begin
            stall_o    = mem_stall_i | alu_stall_s;
            // An unaccepted IDLE request under back-pressure is re-presented later, so not counted here.
            perf_inc_s = (state_r == ST_WAIT) || (alu_stall_s && !mem_stall_i);
        end
    end

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // EX/MEM register: held under MEM back-pressure, each result presented once.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_r  <= 1'b0;
            result_r <= {DATA_W{1'b0}};
            rd_r     <= 5'd0;
        end else if (flush_i) begin
            valid_r  <= 1'b0;
            result_r <= result_r;
            rd_r     <= rd_r;
        end else if (mem_stall_i) begin
            valid_r  <= valid_r;
            result_r <= result_r;
            rd_r     <= rd_r;
        end else if (capture_s) begin
            valid_r  <= 1'b1;
            result_r <= alu_result_i;
            rd_r     <= rd_i;
        end else begin
            valid_r  <= 1'b0;
            result_r <= result_r;
            rd_r     <= rd_r;
        end
    end

    // Stall performance counter, wrapping naturally at its width.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            perf_cnt_r <= {PERF_W{1'b0}};
        end else if (perf_inc_s) begin
            perf_cnt_r <= perf_cnt_r + PERF_W'(1);
        end else begin
            perf_cnt_r <= perf_cnt_r;
        end
    end

    assign busy_o           = (state_r != ST_IDLE);
    assign valid_o          = valid_r;
    assign result_o         = result_r;
    assign rd_o             = rd_r;
    assign perf_stall_cnt_o = perf_cnt_r;

endmodule

// File: tb/tb_riscv_alu_stall_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a cycle-timestamp model of the stall/capture rules.
module tb_riscv_alu_stall_ctrl;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        valid_i;
    logic [4:0]  stall_cycles_i;
    logic [31:0] alu_result_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        mem_stall_i;
    logic        stall_o;
    logic        valid_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;
    logic        busy_o;
    logic [31:0] perf_stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Model: an accepted multicycle instruction is tracked by its accept cycle and N.
    int          cyc;
    bit          m_active;
    int          m_acc;
    int          m_n;
    bit          m_valid;
    logic [31:0] m_result;
    logic [4:0]  m_rd;
    logic [31:0] m_perf;

    riscv_alu_stall_ctrl dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .valid_i          (valid_i),
        .stall_cycles_i   (stall_cycles_i),
        .alu_result_i     (alu_result_i),
        .rd_i             (rd_i),
        .flush_i          (flush_i),
        .mem_stall_i      (mem_stall_i),
        .stall_o          (stall_o),
        .valid_o          (valid_o),
        .result_o         (result_o),
        .rd_o             (rd_o),
        .busy_o           (busy_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_acc    = 0;
        m_n      = 0;
        m_valid  = 1'b0;
        m_result = 32'd0;
        m_rd     = 5'd0;
        m_perf   = 32'd0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model, return at posedge+1.
    task automatic step(input logic v, input logic [4:0] n, input logic [31:0] res,
                        input logic [4:0] rd, input logic fl, input logic ms, input logic rst);
        bit alu_phase;
        bit exp_stall;
        bit cap;
        reset_i        = rst;
        valid_i        = v;
        stall_cycles_i = n;
        alu_result_i   = res;
        rd_i           = rd;
        flush_i        = fl;
        mem_stall_i    = ms;
        @(negedge clock_i);
        alu_phase = m_active && (cyc < m_acc + m_n);
        if (rst)           exp_stall = ms;
        else if (m_active) exp_stall = alu_phase || ms;
        else               exp_stall = ms || (v && (n != 5'd0));
        check_eq("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
        check_eq("busy_o", {31'd0, busy_o}, {31'd0, m_active});
        check_eq("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        check_eq("result_o", result_o, m_result);
        check_eq("rd_o", {27'd0, rd_o}, {27'd0, m_rd});
        check_eq("perf_stall_cnt_o", perf_stall_cnt_o, m_perf);
        if (rst) begin
            model_clear();
        end else begin
            if ((m_active && alu_phase) || (!m_active && v && (n != 5'd0) && !ms))
                m_perf = m_perf + 32'd1;
            cap = 1'b0;
            if (fl) begin
                m_active = 1'b0;
                m_valid  = 1'b0;
            end else begin
                if (m_active) begin
                    if (!alu_phase && !ms) begin
                        cap      = 1'b1;
                        m_active = 1'b0;
                    end
                end else if (v && !ms) begin
                    if (n == 5'd0) begin
                        cap = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_acc    = cyc;
                        m_n      = int'(n);
                    end
                end
                if (!ms) begin
                    m_valid = cap;
                    if (cap) begin
                        m_result = res;
                        m_rd     = rd;
                    end
                end
            end
        end
        cyc++;
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic        v;
        logic [4:0]  n;
        logic        fl;
        logic        ms;
        logic        rst;
        int          r;
        cyc            = 0;
        reset_i        = 1'b1;
        valid_i        = 1'b0;
        stall_cycles_i = 5'd0;
        alu_result_i   = 32'd0;
        rd_i           = 5'd0;
        flush_i        = 1'b0;
        mem_stall_i    = 1'b0;
        model_clear();
        repeat (2) @(posedge clock_i);
        #1;

        // Reset state and combinational result.
        do_reset();
        step(1'b1, 5'd0, 32'h0000_1234, 5'd5, 1'b0, 1'b0, 1'b0);
        check_eq("n0_valid", {31'd0, valid_o}, 32'd1);
        check_eq("n0_result", result_o, 32'h0000_1234);
        check_eq("n0_rd", {27'd0, rd_o}, 32'd5);
        idle();

        // N=3 divide: instruction held in EX while frozen.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 5'd3, 32'hFFFF_FFF9, 5'd7, 1'b0, 1'b0, 1'b0);
        check_eq("n3_valid", {31'd0, valid_o}, 32'd1);
        check_eq("n3_result", result_o, 32'hFFFF_FFF9);
        check_eq("n3_perf", perf_stall_cnt_o, 32'd3);
        idle();

        // N=1 then N=0 back to back.
        do_reset();
        step(1'b1, 5'd1, 32'hAAAA_0001, 5'd3, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd1, 32'hAAAA_0001, 5'd3, 1'b0, 1'b0, 1'b0);
        check_eq("n1_result", result_o, 32'hAAAA_0001);
        step(1'b1, 5'd0, 32'hBBBB_0002, 5'd4, 1'b0, 1'b0, 1'b0);
        check_eq("n0b_valid", {31'd0, valid_o}, 32'd1);
        check_eq("n0b_result", result_o, 32'hBBBB_0002);
        check_eq("n1_perf", perf_stall_cnt_o, 32'd1);
        idle();

        // N=4 with MEM back-pressure over t+3..t+5.
        do_reset();
        for (int k = 0; k < 7; k++)
            step(1'b1, 5'd4, 32'h0C0F_FEE0, 5'd9, 1'b0, (k >= 3) && (k <= 5), 1'b0);
        check_eq("ms_valid", {31'd0, valid_o}, 32'd1);
        check_eq("ms_perf", perf_stall_cnt_o, 32'd4);
        idle();

        // N=5 flushed at t+2.
        do_reset();
        step(1'b1, 5'd5, 32'h5555_5555, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 32'h5555_5555, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 5'd5, 32'h5555_5555, 5'd1, 1'b1, 1'b0, 1'b0);
        check_eq("fl_busy", {31'd0, busy_o}, 32'd0);
        idle();
        check_eq("fl_valid", {31'd0, valid_o}, 32'd0);
        check_eq("fl_perf", perf_stall_cnt_o, 32'd3);

        // N=31 with reset landing mid-countdown.
        do_reset();
        for (int k = 0; k < 10; k++) step(1'b1, 5'd31, 32'h3131_3131, 5'd31, 1'b0, 1'b0, 1'b0);
        check_eq("n31_busy_mid", {31'd0, busy_o}, 32'd1);
        do_reset();
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
        check_eq("rst_perf", perf_stall_cnt_o, 32'd0);
        idle();

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            v  = ($urandom_range(0, 99) < 70);
            r  = int'($urandom_range(0, 99));
            n  = (r < 45) ? 5'd0 : ((r < 97) ? 5'($urandom_range(1, 6)) : 5'd31);
            ms = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 4);
            rst = ($urandom_range(0, 199) == 0);
            step(v, n, $urandom, 5'($urandom_range(0, 31)), fl, ms, rst);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
